// File: rtl/adc_pkg.sv
// Shared types and constants for the ADS8528 frame scheduler.
package adc_pkg;

    localparam int unsigned ADC_W     = 16;
    localparam int unsigned ERR_W     = 3;
    localparam int unsigned OVR_CNT_W = 8;

    localparam int unsigned ERR_OVR   = 0;
    localparam int unsigned ERR_TMO   = 1;
    localparam int unsigned ERR_STRAY = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        START     = 3'd2,
        COLLECT   = 3'd3,
        PRESENT   = 3'd4
    } sched_state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate tick: one registered pulse every CLK_DIV cycles while enabled.
module sample_tick_gen #(
    parameter int unsigned CLK_DIV = 500
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int unsigned     CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count 0..CLK_DIV-1 while enabled, hold at zero otherwise.
    always_comb begin
        cnt_d = '0;
        if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // tick is registered so it is high exactly while the count sits at LAST.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tick  <= (cnt_d == LAST);
        end
    end

endmodule

// File: rtl/adc_frame_scheduler.sv
// Paces ADC conversions, assembles per-channel words into timestamped frames,
// and presents them downstream over valid/ready while tracking error events.
module adc_frame_scheduler
    import adc_pkg::*;
#(
    parameter int unsigned CLK_DIV = 500,
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned TS_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    output logic                    conv_start,
    input  logic                    sample_valid,
    input  logic [ADC_W-1:0]        sample_data,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic [ADC_W*NUM_CH-1:0] frame_data,
    output logic [TS_W-1:0]         frame_ts,
    output logic [ERR_W-1:0]        err,
    input  logic                    err_clr,
    output logic [OVR_CNT_W-1:0]    overrun_cnt
);

    localparam int unsigned FRAME_W = ADC_W * NUM_CH;
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);

    localparam logic [CH_W-1:0]      LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [OVR_CNT_W-1:0] OVR_MAX  = '1;

    sched_state_t         state_q;
    sched_state_t         state_d;
    logic                 tick;
    logic [TS_W-1:0]      ts_q;
    logic [CH_W-1:0]      ch_idx_q;
    logic [TMO_W-1:0]     tmo_cnt_q;
    logic [FRAME_W-1:0]   lane_q;
    logic [FRAME_W-1:0]   lane_d;
    logic                 accept_c;
    logic                 done_c;
    logic                 tmo_c;
    logic                 ovr_c;
    logic                 stray_c;

    sample_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus per-cycle event strobes.
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        done_c   = 1'b0;
        tmo_c    = 1'b0;
        ovr_c    = 1'b0;
        stray_c  = sample_valid && (state_q != COLLECT);
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (tick) begin
                    state_d = START;
                end else if (!enable) begin
                    state_d = IDLE;
                end
            end
            START: begin
                ovr_c   = tick;
                state_d = COLLECT;
            end
            COLLECT: begin
                ovr_c = tick;
                if (sample_valid) begin
                    accept_c = 1'b1;
                    if (ch_idx_q == LAST_CH) begin
                        done_c  = 1'b1;
                        state_d = PRESENT;
                    end
                end
                // A completing word in the last allowed cycle still wins.
                if (!done_c && (tmo_cnt_q == TMO_LAST)) begin
                    tmo_c   = 1'b1;
                    state_d = WAIT_TICK;
                end
            end
            PRESENT: begin
                if (frame_ready) begin
                    if (tick) begin
                        state_d = START;
                    end else if (enable) begin
                        state_d = WAIT_TICK;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    ovr_c = tick;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Assembly buffer with the incoming word merged into its lane.
    always_comb begin
        lane_d = lane_q;
        if (accept_c) begin
            lane_d[ch_idx_q*ADC_W +: ADC_W] = sample_data;
        end
    end

    // Free-running timestamp.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    // Channel index, COLLECT cycle counter and partial-frame buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_idx_q  <= '0;
            tmo_cnt_q <= '0;
            lane_q    <= '0;
        end else if (state_q == START) begin
            ch_idx_q  <= '0;
            tmo_cnt_q <= '0;
            lane_q    <= '0;
        end else if (state_q == COLLECT) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            lane_q    <= lane_d;
            if (accept_c) begin
                ch_idx_q <= ch_idx_q + CH_W'(1);
            end
        end
    end

    // Registered handshake outputs and frame payload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conv_start  <= 1'b0;
            frame_valid <= 1'b0;
            frame_data  <= '0;
            frame_ts    <= '0;
        end else begin
            conv_start  <= (state_d == START);
            frame_valid <= (state_d == PRESENT);
            if (done_c) begin
                frame_data <= lane_d;
            end
            if (state_q == START) begin
                frame_ts <= ts_q;
            end
        end
    end

    // Sticky error flags and saturating overrun count; clear beats set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err         <= '0;
            overrun_cnt <= '0;
        end else if (err_clr) begin
            err         <= '0;
            overrun_cnt <= '0;
        end else begin
            if (ovr_c) begin
                err[ERR_OVR] <= 1'b1;
                if (overrun_cnt != OVR_MAX) begin
                    overrun_cnt <= overrun_cnt + OVR_CNT_W'(1);
                end
            end
            if (tmo_c) begin
                err[ERR_TMO] <= 1'b1;
            end
            if (stray_c) begin
                err[ERR_STRAY] <= 1'b1;
            end
        end
    end

endmodule

// File: doc/adc_frame_scheduler.md
# adc_frame_scheduler

Sequences the ADS8528 parallel driver at a fixed sample rate for sound localization. A programmable tick starts each conversion. The scheduler then collects the per-channel words the driver returns, assembles them into one timestamped frame, and hands the frame downstream over a valid/ready handshake. It sits between the ADC driver and the sample memory/correlation logic, and it flags overrun, timeout and protocol errors.

## Interface
Parameters:
- CLK_DIV, 500: sample period in clk cycles (≥ 4).
- NUM_CH, 4: channel words per frame (1–8).
- TIMEOUT, 1024: max cycles allowed in COLLECT.
- TS_W, 32: timestamp width.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  run request; level-sensitive.
- conv_start  out  1  one-cycle pulse telling the driver to begin conversion.
- sample_valid  in  1  driver presents one channel word this cycle.
- sample_data  in  16  channel word, arriving in channel order 0..NUM_CH-1.
- frame_valid  out  1  frame available.
- frame_ready  in  1  downstream accepts the frame.
- frame_data  out  16*NUM_CH  channel k in bits [16k+15:16k].
- frame_ts  out  TS_W  timestamp latched at conv_start.
- err  out  3  sticky: [0] overrun, [1] timeout, [2] stray sample.
- err_clr  in  1  synchronous clear of err; has priority over new sets in the same cycle.
- overrun_cnt  out  8  saturating count of dropped ticks.

## Operation
- Timestamp counter: free-running from reset, increments every cycle, wraps modulo 2^TS_W.
- Tick counter: runs 0..CLK_DIV-1 while enable=1; tick is asserted when the count equals CLK_DIV-1. When enable=0 the counter is held at 0.
- State IDLE: enable=1 moves to WAIT_TICK.
- State WAIT_TICK: on tick, go to START. If enable=0, go to IDLE.
- State START: drive conv_start=1 for exactly this cycle, latch frame_ts, clear ch_idx, then go to COLLECT.
- State COLLECT:
  - On sample_valid, write sample_data into lane ch_idx and increment ch_idx.
  - When the word for ch_idx=NUM_CH-1 is accepted, go to PRESENT.
  - If the cycle counter reaches TIMEOUT, set err[1], discard the partial frame and go to WAIT_TICK.
- State PRESENT:
  - frame_valid=1; frame_data and frame_ts are held stable until frame_ready.
  - On frame_ready: go to START if tick is in the same cycle; otherwise go to WAIT_TICK, or to IDLE if enable=0.
- Overrun: a tick in START, in COLLECT, or in PRESENT without frame_ready sets err[0] and increments overrun_cnt. overrun_cnt saturates at 255 and is cleared by err_clr. The tick is dropped, not queued.
- Stray sample: sample_valid outside COLLECT sets err[2]; the data is ignored.
- enable deassert mid-frame: the current frame completes and is presented; the scheduler then returns to IDLE.
- Reset may be asserted in any state. All state, counters and outputs return to reset values immediately; any frame in progress is lost.

## Timing
- Reset values: conv_start=0, frame_valid=0, frame_data=0, frame_ts=0, err=0, overrun_cnt=0, state=IDLE, all counters 0.
- Tick to conv_start: 1 cycle (tick seen in cycle n, conv_start=1 in cycle n+1).
- Last sample_valid to frame_valid: 1 cycle.
- frame_valid falls in the cycle after the frame_ready handshake.
- A back-to-back tick on the handshake cycle produces conv_start in the next cycle.
- All outputs are registered; no combinational path from input to output.

## Structure
- Package adc_pkg holds:
  - the sched_state_t enum (IDLE, WAIT_TICK, START, COLLECT, PRESENT);
  - error-bit index constants ERR_OVR=0, ERR_TMO=1, ERR_STRAY=2;
  - ADC_W=16.
- Sub-module sample_tick_gen (CLK_DIV, with clk, rst, enable, tick). Everything else stays in adc_frame_scheduler.

## Test plan
- Basic frame: CLK_DIV=20, NUM_CH=4, enable=1, driver returns 0x1111..0x4444 three cycles after conv_start, frame_ready=1 → conv_start every 20 cycles, frame_data=0x4444_3333_2222_1111, frame_ts = the timestamp at the conv_start cycle, err=0.
- Backpressure/overrun: hold frame_ready=0 for 45 cycles with CLK_DIV=20 → frame held stable, err[0]=1, overrun_cnt=2. Then assert err_clr → err=0, overrun_cnt=0.
- Timeout: TIMEOUT=16, driver returns only 2 of 4 words → err[1]=1 at cycle 16 of COLLECT, no frame_valid, next tick issues conv_start.
- Stray and simultaneous: sample_valid pulse in WAIT_TICK → err[2]=1, data ignored. Separately, frame_ready coincides with tick → conv_start next cycle and overrun_cnt unchanged.
- Reset/enable: assert rst mid-COLLECT → all outputs 0 asynchronously, IDLE after release. Deassert enable mid-COLLECT → that frame is still presented, then no further conv_start.
